// File: rtl/geom_recon_seq.sv
// Reconstruction sequencer for the LiDAR geometry decompressor.
// Turns a framed stream of signed residuals into absolute points by delta
// prediction against the previously reconstructed point, with per-axis
// saturating addition. Absolute key points bypass prediction.
module geom_recon_seq #(
  parameter int CNT_W     = 20,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_points,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [31:0]          res_x,
  input  logic [31:0]          res_y,
  input  logic [31:0]          res_z,
  input  logic                 res_abs,
  output logic                 pt_valid,
  input  logic                 pt_ready,
  output logic [31:0]          pt_x,
  output logic [31:0]          pt_y,
  output logic [31:0]          pt_z,
  output logic                 pt_sat,
  output logic                 pt_last,
  output logic                 busy,
  output logic                 done,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] count;
  logic [31:0]      pred_x, pred_y, pred_z;
  logic [32:0]      sum_x, sum_y, sum_z;
  logic [31:0]      nxt_x, nxt_y, nxt_z;
  logic             nxt_sat;
  logic             accept;
  logic             out_hs;
  logic             last_accept;

  // Bit 32 flags a clamp; bits 31:0 carry the clamped 32-bit result.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      sat_add = {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    else
      sat_add = {1'b0, s[31:0]};
  endfunction

  // Handshake qualifiers; res_ready depends only on state and the output side.
  always_comb begin
    res_ready   = (state == RUN) && (!pt_valid || pt_ready);
    accept      = res_valid && res_ready;
    out_hs      = pt_valid && pt_ready;
    last_accept = accept && (count == n_q - 1'b1);
    busy        = (state != IDLE);
  end

  // Next reconstructed point: prediction from the last accepted point or absolute.
  always_comb begin
    sum_x   = sat_add(pred_x, res_x);
    sum_y   = sat_add(pred_y, res_y);
    sum_z   = sat_add(pred_z, res_z);
    nxt_x   = res_abs ? res_x : sum_x[31:0];
    nxt_y   = res_abs ? res_y : sum_y[31:0];
    nxt_z   = res_abs ? res_z : sum_z[31:0];
    nxt_sat = !res_abs && (sum_x[32] || sum_y[32] || sum_z[32]);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (num_points != '0)) state_nx = RUN;
      RUN:     if (last_accept)                 state_nx = DRAIN;
      DRAIN:   if (out_hs)                      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: frame setup, point register, predictor, counters, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      count    <= '0;
      pred_x   <= '0;
      pred_y   <= '0;
      pred_z   <= '0;
      pt_valid <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
      pt_z     <= '0;
      pt_sat   <= 1'b0;
      pt_last  <= 1'b0;
      done     <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sat_cnt <= '0;
            if (num_points != '0) begin
              n_q    <= num_points;
              count  <= '0;
              pred_x <= '0;
              pred_y <= '0;
              pred_z <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            pt_x     <= nxt_x;
            pt_y     <= nxt_y;
            pt_z     <= nxt_z;
            pt_sat   <= nxt_sat;
            pt_valid <= 1'b1;
            pred_x   <= nxt_x;
            pred_y   <= nxt_y;
            pred_z   <= nxt_z;
            count    <= count + 1'b1;
            if (nxt_sat && (sat_cnt != '1)) sat_cnt <= sat_cnt + 1'b1;
            if (last_accept) pt_last <= 1'b1;
          end else if (out_hs) begin
            pt_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            pt_valid <= 1'b0;
            pt_last  <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_geom_recon_seq.sv
// Scoreboard bench for geom_recon_seq: a reference model computes each
// reconstructed point when its residual is accepted; the monitor pops and
// compares when the point is handed off downstream.
module tb_geom_recon_seq;
  localparam int CNT_W     = 20;
  localparam int SAT_CNT_W = 16;

  logic                 clk, rst, start;
  logic [CNT_W-1:0]     num_points;
  logic                 res_valid, res_ready, res_abs;
  logic [31:0]          res_x, res_y, res_z;
  logic                 pt_valid, pt_ready, pt_sat, pt_last, busy, done;
  logic [31:0]          pt_x, pt_y, pt_z;
  logic [SAT_CNT_W-1:0] sat_cnt;

  geom_recon_seq #(.CNT_W(CNT_W), .SAT_CNT_W(SAT_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_points(num_points),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_abs(res_abs),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_sat(pt_sat), .pt_last(pt_last),
    .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x, y, z;
    logic        sat, last;
  } pt_t;

  pt_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mp_x, mp_y, mp_z;
  int          m_n, m_idx, m_sat;
  bit          bp = 0;
  bit          zero_pend = 0;
  bit          exp_done = 0;
  bit          prev_stall = 0;
  pt_t         held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] madd(input logic [31:0] p, input logic [31:0] r, output bit c);
    longint s;
    s = longint'($signed(p)) + longint'($signed(r));
    c = 1'b0;
    if (s > 64'sd2147483647) begin c = 1'b1; return 32'h7FFF_FFFF; end
    if (s < -64'sd2147483648) begin c = 1'b1; return 32'h8000_0000; end
    return s[31:0];
  endfunction

  // Downstream ready: constant high, or toggling every cycle under backpressure.
  initial begin
    pt_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pt_ready = bp ? !pt_ready : 1'b1;
    end
  end

  // Monitor: done timing, stall stability, scoreboard comparison.
  initial begin
    pt_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        exp_done   = 0;
        continue;
      end
      check("done", done, exp_done);
      exp_done = 0;
      if (zero_pend) begin exp_done = 1; zero_pend = 0; end
      if (prev_stall) begin
        check("stall_xy", {pt_x, pt_y}, {held.x, held.y});
        check("stall_z", {pt_z, pt_sat, pt_last}, {held.z, held.sat, held.last});
      end
      if (pt_valid && pt_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pt", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pt_xy", {pt_x, pt_y}, {e.x, e.y});
          check("pt_z", pt_z, e.z);
          check("pt_sat_last", {pt_sat, pt_last}, {e.sat, e.last});
          if (e.last) exp_done = 1;
        end
      end
      prev_stall = pt_valid && !pt_ready;
      held = '{x: pt_x, y: pt_y, z: pt_z, sat: pt_sat, last: pt_last};
    end
  end

  task automatic start_frame(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_points = n[CNT_W-1:0];
    if (n == 0) zero_pend = 1;
    mp_x = '0; mp_y = '0; mp_z = '0;
    m_n = n; m_idx = 0; m_sat = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, (n > 0));
    check("res_ready_after_start", res_ready, (n > 0));
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input bit abs, output int waits);
    pt_t e;
    bit  cx, cy, cz;
    res_x = x; res_y = y; res_z = z; res_abs = abs; res_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!res_ready && waits < 200) begin waits++; @(negedge clk); end
    if (!res_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      if (abs) begin
        e.x = x; e.y = y; e.z = z; e.sat = 1'b0;
      end else begin
        e.x = madd(mp_x, x, cx);
        e.y = madd(mp_y, y, cy);
        e.z = madd(mp_z, z, cz);
        e.sat = cx | cy | cz;
      end
      e.last = (m_idx == m_n - 1);
      m_idx++;
      if (e.sat && m_sat < 65535) m_sat++;
      mp_x = e.x; mp_y = e.y; mp_z = e.z;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sb.size() != 0) && k < 300) begin @(posedge clk); #1; k++; end
    repeat (2) @(posedge clk);
    #1;
    check("frame_end_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
    check("sat_cnt", sat_cnt, m_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; num_points = '0; res_valid = 1'b0;
    res_x = '0; res_y = '0; res_z = '0; res_abs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {res_ready, pt_valid, pt_sat, pt_last, busy, done}, 0);
    check("rst_pt_xy", {pt_x, pt_y}, 0);
    check("rst_pt_z_sat", {pt_z, sat_cnt}, 0);
    rst = 1'b0;

    // Basic prediction, full throughput.
    start_frame(3);
    send(32'd1, 32'd2, 32'd3, 0, w);          check("tp_wait", w, 0);
    send(32'd10, -32'sd5, 32'd0, 0, w);       check("tp_wait", w, 0);
    send(-32'sd1, -32'sd1, -32'sd1, 0, w);    check("tp_wait", w, 0);
    wait_idle();
    check("sat_cnt_zero", sat_cnt, 0);

    // Saturation on both ends.
    start_frame(2);
    send(32'h7FFF_FFF0, 32'd0, 32'h8000_0001, 0, w);
    send(32'h20, 32'd0, -32'sd5, 0, w);
    wait_idle();
    check("sat_cnt_one", sat_cnt, 1);

    // Absolute key point resets the predictor.
    start_frame(3);
    send(32'd5, 32'd5, 32'd5, 0, w);
    send(32'd100, 32'd200, 32'd300, 1, w);
    send(32'd1, 32'd1, 32'd1, 0, w);
    wait_idle();

    // Backpressure with residuals always offered.
    bp = 1;
    start_frame(4);
    for (int i = 0; i < 4; i++)
      send($urandom, $urandom, $urandom_range(1000), 0, w);
    wait_idle();
    bp = 0;

    // Zero-length frame, then a start during RUN that must be ignored.
    start_frame(0);
    repeat (2) @(posedge clk);
    #1;
    check("zero_busy_ready", {busy, res_ready}, 0);
    start_frame(2);
    start = 1'b1; num_points = 5;
    @(posedge clk); #1;
    start = 1'b0;
    send(32'd3, 32'd4, 32'd5, 0, w);
    send(32'd1, -32'sd9, 32'd2, 0, w);
    wait_idle();

    // Reset mid-frame discards the in-flight point and produces no done.
    start_frame(5);
    send(32'd11, 32'd12, 32'd13, 0, w);
    send(32'd1, 32'd1, 32'd1, 0, w);
    rst = 1'b1;
    #1;
    check("midrst_ctrl", {pt_valid, pt_last, busy, res_ready}, 0);
    check("midrst_pt", {pt_x, pt_z}, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    start_frame(1);
    send(32'd7, 32'd7, 32'd7, 0, w);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
